// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, controller states and read-tag type
// for the burst reader and its data-alignment pipeline.
package sdram_pkg;

    // Commands are {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_BURST_TER = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        WAIT_TRCD,
        READ,
        READ_DATA,
        PRECHARGE,
        WAIT_TRP,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/sdram_rd_pipe.sv
// Delays word tags by CAS_LAT+1 cycles so they line up with the once-registered
// SDRAM read data; rd_data is forced to zero whenever the tag is not valid.
module sdram_rd_pipe
    import sdram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CAS_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  rd_tag_t           tag_i,
    input  logic [DATA_W-1:0] dq_i,
    output logic              rd_valid_o,
    output logic              rd_first_o,
    output logic              rd_last_o,
    output logic [DATA_W-1:0] rd_data_o
);

    rd_tag_t           tag_q [CAS_LAT+1];
    logic [DATA_W-1:0] dq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i <= CAS_LAT; i++) begin
                tag_q[i] <= '0;
            end
            dq_q <= '0;
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i <= CAS_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            dq_q <= dq_i;
        end
    end

    assign rd_valid_o = tag_q[CAS_LAT].valid;
    assign rd_first_o = tag_q[CAS_LAT].first;
    assign rd_last_o  = tag_q[CAS_LAT].last;
    assign rd_data_o  = tag_q[CAS_LAT].valid ? dq_q : '0;

endmodule

// File: rtl/sdram_burst_reader.sv
// SDRAM read controller: splits a request into page-bounded full-page bursts,
// each ended by BURST_TERMINATE and closed with PRECHARGE.
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BANK_W  = 2,
    parameter int ROW_W   = 12,
    parameter int COL_W   = 8,
    parameter int LEN_W   = 10,
    parameter int CAS_LAT = 3,
    parameter int TRCD    = 2,
    parameter int TRP     = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          init_end,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [BANK_W+ROW_W+COL_W-1:0] req_addr,
    input  logic [LEN_W-1:0]              req_len,
    input  logic [DATA_W-1:0]             sdram_dq,
    output logic [3:0]                    cmd_o,
    output logic [BANK_W-1:0]             ba_o,
    output logic [ROW_W-1:0]              addr_o,
    output logic                          rd_valid,
    output logic                          rd_first,
    output logic                          rd_last,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          busy,
    output logic                          done
);

    localparam int               REM_W      = LEN_W + 1;
    localparam int               CNT_W      = LEN_W + 2;
    localparam logic [REM_W-1:0] PAGE_WORDS = REM_W'(1) << COL_W;
    localparam logic [ROW_W-1:0] A10_MASK   = ROW_W'(1 << 10);

    state_t            state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [REM_W-1:0]  seg_q, seg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [REM_W-1:0]  page_left;
    logic [REM_W-1:0]  seg_now;
    logic [CNT_W-1:0]  last_idx;
    rd_tag_t           tag;

    assign page_left = PAGE_WORDS - REM_W'(col_q);
    assign seg_now   = (rem_q < page_left) ? rem_q : page_left;
    assign last_idx  = CNT_W'(seg_q) + CNT_W'(CAS_LAT - 1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rem_q   <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rem_q   <= rem_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        row_d     = row_q;
        col_d     = col_q;
        rem_d     = rem_q;
        seg_d     = seg_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        req_ready = 1'b0;
        cmd_o     = CMD_NOP;
        ba_o      = '1;
        addr_o    = '1;
        tag       = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = init_end;
                if (req_valid && init_end) begin
                    {bank_d, row_d, col_d} = req_addr;
                    rem_d   = REM_W'(req_len);
                    first_d = 1'b1;
                    cnt_d   = '0;
                    state_d = (req_len == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                cmd_o   = CMD_ACTIVE;
                ba_o    = bank_q;
                addr_o  = row_q;
                cnt_d   = '0;
                state_d = WAIT_TRCD;
            end
            WAIT_TRCD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TRCD - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            // The READ cycle is index 0 and already launches the segment's first word tag
            READ: begin
                cmd_o     = CMD_READ;
                ba_o      = bank_q;
                addr_o    = ROW_W'(col_q) & ~A10_MASK;
                seg_d     = seg_now;
                tag.valid = 1'b1;
                tag.first = first_q;
                tag.last  = (rem_q == REM_W'(1));
                first_d   = 1'b0;
                rem_d     = rem_q - REM_W'(1);
                cnt_d     = CNT_W'(1);
                state_d   = READ_DATA;
            end
            READ_DATA: begin
                if (cnt_q < CNT_W'(seg_q)) begin
                    tag.valid = 1'b1;
                    tag.last  = (rem_q == REM_W'(1));
                    rem_d     = rem_q - REM_W'(1);
                end
                if (cnt_q == CNT_W'(seg_q)) begin
                    cmd_o = CMD_BURST_TER;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == last_idx) begin
                    state_d = PRECHARGE;
                end
            end
            PRECHARGE: begin
                cmd_o   = CMD_PRECHARGE;
                ba_o    = bank_q;
                addr_o  = '0;
                cnt_d   = '0;
                state_d = WAIT_TRP;
            end
            WAIT_TRP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TRP - 1)) begin
                    cnt_d = '0;
                    if (rem_q != '0) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                        if (row_q == '1) begin
                            bank_d = bank_q + BANK_W'(1);
                        end
                        state_d = ACTIVE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    sdram_rd_pipe #(
        .DATA_W  (DATA_W),
        .CAS_LAT (CAS_LAT)
    ) u_rd_pipe (
        .clk_i      (sys_clk),
        .rst_n_i    (sys_rst_n),
        .tag_i      (tag),
        .dq_i       (sdram_dq),
        .rd_valid_o (rd_valid),
        .rd_first_o (rd_first),
        .rd_last_o  (rd_last),
        .rd_data_o  (rd_data)
    );

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader with a behavioural SDRAM whose word at
// {bank,row,col} reads back as {bank, row[5:0], col}.
module tb_sdram_burst_reader;
    import sdram_pkg::*;

    localparam int CAS_LAT = 3;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end  = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [21:0] req_addr  = '0;
    logic [9:0]  req_len   = '0;
    logic [15:0] sdram_dq  = '0;
    logic [3:0]  cmd_o;
    logic [1:0]  ba_o;
    logic [11:0] addr_o;
    logic        rd_valid, rd_first, rd_last;
    logic [15:0] rd_data;
    logic        busy, done;

    int passCount  = 0;
    int checkCount = 0;
    int cyc        = 0;

    int          cmdCyc[$];
    logic [3:0]  cmdCode[$];
    logic [1:0]  cmdBa[$];
    logic [11:0] cmdAddr[$];
    int          rdCyc[$];
    logic [15:0] rdDataQ[$];
    logic        rdFirstQ[$];
    logic        rdLastQ[$];
    int          doneCyc[$];
    int          zeroDataViol = 0;

    int          mReadCyc = -1;
    int          mCol     = 0;
    int          mBst     = 0;
    int          mK       = 0;
    logic [1:0]  mBank    = '0;
    logic [11:0] mRow     = '0;

    sdram_burst_reader dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .init_end  (init_end),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .sdram_dq  (sdram_dq),
        .cmd_o     (cmd_o),
        .ba_o      (ba_o),
        .addr_o    (addr_o),
        .rd_valid  (rd_valid),
        .rd_first  (rd_first),
        .rd_last   (rd_last),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [15:0] memWord(input logic [1:0] b, input logic [11:0] r, input int c);
        logic [7:0] cc;
        cc = 8'(c);
        return {b, r[5:0], cc};
    endfunction

    // Monitor logs command/data/done activity; the SDRAM model then drives dq for this cycle
    always @(negedge sys_clk) begin
        if (cmd_o !== CMD_NOP) begin
            cmdCyc.push_back(cyc);
            cmdCode.push_back(cmd_o);
            cmdBa.push_back(ba_o);
            cmdAddr.push_back(addr_o);
        end
        if (rd_valid === 1'b1) begin
            rdCyc.push_back(cyc);
            rdDataQ.push_back(rd_data);
            rdFirstQ.push_back(rd_first);
            rdLastQ.push_back(rd_last);
        end else if (rd_data !== 16'h0000) begin
            zeroDataViol++;
        end
        if (done === 1'b1) doneCyc.push_back(cyc);
        if (!sys_rst_n) begin
            mReadCyc = -1;
        end else if (cmd_o === CMD_ACTIVE) begin
            mBank = ba_o;
            mRow  = addr_o;
        end else if (cmd_o === CMD_READ) begin
            mReadCyc = cyc;
            mCol     = int'(addr_o[7:0]);
            mBst     = 1 << 30;
        end else if (cmd_o === CMD_BURST_TER && mReadCyc >= 0) begin
            mBst = cyc - mReadCyc;
        end
        mK = cyc - mReadCyc - CAS_LAT;
        if (mReadCyc >= 0 && mK >= 0 && mK < mBst && mCol + mK < 256)
            sdram_dq = memWord(mBank, mRow, mCol + mK);
        else
            sdram_dq = 16'hF00F;
    end

    task automatic clearLogs();
        cmdCyc.delete(); cmdCode.delete(); cmdBa.delete(); cmdAddr.delete();
        rdCyc.delete(); rdDataQ.delete(); rdFirstQ.delete(); rdLastQ.delete();
        doneCyc.delete();
    endtask

    task automatic sendReq(input logic [1:0] b, input logic [11:0] r, input logic [7:0] c,
                           input logic [9:0] len, output int acc, output logic rdy);
        @(negedge sys_clk);
        req_valid = 1'b1;
        req_addr  = {b, r, c};
        req_len   = len;
        acc       = cyc;
        #1 rdy    = req_ready;
        @(negedge sys_clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            #1;
            if (doneCyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        init_end  = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        checkCount++;
        if ({cmd_o, ba_o, addr_o} !== {CMD_NOP, 2'b11, 12'hFFF})
            $display("FAIL reset_bus got %h expected %h", {cmd_o, ba_o, addr_o}, {CMD_NOP, 2'b11, 12'hFFF});
        else passCount++;
        checkCount++;
        if ({rd_valid, rd_first, rd_last, done, busy, req_ready} !== 6'b000000)
            $display("FAIL reset_flags got %b expected 000000", {rd_valid, rd_first, rd_last, done, busy, req_ready});
        else passCount++;
        checkCount++;
        if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h expected 0000", rd_data);
        else passCount++;
        sys_rst_n = 1'b1;
        init_end  = 1'b1;
        @(negedge sys_clk);
        #1;
        checkCount++;
        if ({req_ready, busy} !== 2'b10) $display("FAIL idle_ready got %b expected 10", {req_ready, busy});
        else passCount++;
    endtask

    task automatic test_basic();
        int a, t; logic rdy; bit ok;
        logic [63:0] got, exp;
        logic [33:0] gw, ew;
        int eOff[4]; logic [3:0] eCode[4]; logic [1:0] eBa[4]; logic [11:0] eAddr[4];
        eOff  = '{0, 3, 7, 10};
        eCode = '{CMD_ACTIVE, CMD_READ, CMD_BURST_TER, CMD_PRECHARGE};
        eBa   = '{2'd1, 2'd1, 2'b11, 2'd1};
        eAddr = '{12'd5, 12'd10, 12'hFFF, 12'd0};
        clearLogs();
        sendReq(2'd1, 12'd5, 8'd10, 10'd4, a, rdy);
        t = a + 1;
        checkCount++;
        if (rdy !== 1'b1) $display("FAIL basic_ready got %b expected 1", rdy); else passCount++;
        waitDone(100, ok);
        checkCount++;
        if (ok !== 1'b1) $display("FAIL basic_timeout got %b expected 1", ok); else passCount++;
        checkCount++;
        if (cmdCyc.size() !== 4) $display("FAIL basic_cmd_count got %0d expected 4", cmdCyc.size()); else passCount++;
        for (int i = 0; i < 4 && i < cmdCyc.size(); i++) begin
            got = {32'(cmdCyc[i] - t), 14'(0), cmdCode[i], cmdBa[i], cmdAddr[i]};
            exp = {32'(eOff[i]), 14'(0), eCode[i], eBa[i], eAddr[i]};
            checkCount++;
            if (got !== exp) $display("FAIL basic_cmd[%0d] got %h expected %h", i, got, exp); else passCount++;
        end
        checkCount++;
        if (rdCyc.size() !== 4) $display("FAIL basic_rd_count got %0d expected 4", rdCyc.size()); else passCount++;
        for (int i = 0; i < 4 && i < rdCyc.size(); i++) begin
            gw = {16'(rdCyc[i] - t), rdDataQ[i], rdFirstQ[i], rdLastQ[i]};
            ew = {16'(7 + i), memWord(2'd1, 12'd5, 10 + i), i == 0, i == 3};
            checkCount++;
            if (gw !== ew) $display("FAIL basic_word[%0d] got %h expected %h", i, gw, ew); else passCount++;
        end
        checkCount++;
        if (doneCyc.size() !== 1 || doneCyc[0] - t !== 13)
            $display("FAIL basic_done got count %0d expected 1 at offset 13", doneCyc.size());
        else passCount++;
    endtask

    task automatic test_page_cross();
        int a, t; logic rdy; bit ok;
        logic [63:0] got, exp;
        logic [33:0] gw, ew;
        int eOff[8]; logic [3:0] eCode[8]; logic [11:0] eAddr[8];
        eOff  = '{0, 3, 9, 12, 15, 18, 22, 25};
        eCode = '{CMD_ACTIVE, CMD_READ, CMD_BURST_TER, CMD_PRECHARGE,
                  CMD_ACTIVE, CMD_READ, CMD_BURST_TER, CMD_PRECHARGE};
        eAddr = '{12'd7, 12'd250, 12'hFFF, 12'd0, 12'd8, 12'd0, 12'hFFF, 12'd0};
        clearLogs();
        sendReq(2'd0, 12'd7, 8'd250, 10'd10, a, rdy);
        t = a + 1;
        waitDone(200, ok);
        checkCount++;
        if (ok !== 1'b1) $display("FAIL cross_timeout got %b expected 1", ok); else passCount++;
        checkCount++;
        if (cmdCyc.size() !== 8) $display("FAIL cross_cmd_count got %0d expected 8", cmdCyc.size()); else passCount++;
        for (int i = 0; i < 8 && i < cmdCyc.size(); i++) begin
            got = {32'(cmdCyc[i] - t), 16'(0), cmdCode[i], cmdAddr[i]};
            exp = {32'(eOff[i]), 16'(0), eCode[i], eAddr[i]};
            checkCount++;
            if (got !== exp) $display("FAIL cross_cmd[%0d] got %h expected %h", i, got, exp); else passCount++;
        end
        checkCount++;
        if (rdCyc.size() !== 10) $display("FAIL cross_rd_count got %0d expected 10", rdCyc.size()); else passCount++;
        for (int i = 0; i < 10 && i < rdCyc.size(); i++) begin
            gw = {16'(rdCyc[i] - t), rdDataQ[i], rdFirstQ[i], rdLastQ[i]};
            if (i < 6) ew = {16'(7 + i), memWord(2'd0, 12'd7, 250 + i), i == 0, 1'b0};
            else       ew = {16'(16 + i), memWord(2'd0, 12'd8, i - 6), 1'b0, i == 9};
            checkCount++;
            if (gw !== ew) $display("FAIL cross_word[%0d] got %h expected %h", i, gw, ew); else passCount++;
        end
        checkCount++;
        if (doneCyc.size() !== 1 || doneCyc[0] - t !== 28)
            $display("FAIL cross_done got count %0d expected 1 at offset 28", doneCyc.size());
        else passCount++;
    endtask

    task automatic test_bank_wrap();
        int a, t; logic rdy; bit ok;
        logic [63:0] got, exp;
        logic [33:0] gw, ew;
        clearLogs();
        sendReq(2'd3, 12'hFFF, 8'd255, 10'd2, a, rdy);
        t = a + 1;
        waitDone(200, ok);
        checkCount++;
        if (cmdCyc.size() !== 8) $display("FAIL wrap_cmd_count got %0d expected 8", cmdCyc.size()); else passCount++;
        if (cmdCyc.size() >= 6) begin
            got = {32'(cmdCyc[4] - t), 14'(0), cmdCode[4], cmdBa[4], cmdAddr[4]};
            exp = {32'd10, 14'(0), CMD_ACTIVE, 2'd0, 12'd0};
            checkCount++;
            if (got !== exp) $display("FAIL wrap_second_act got %h expected %h", got, exp); else passCount++;
            got = {32'(cmdCyc[5] - t), 14'(0), cmdCode[5], cmdBa[5], cmdAddr[5]};
            exp = {32'd13, 14'(0), CMD_READ, 2'd0, 12'd0};
            checkCount++;
            if (got !== exp) $display("FAIL wrap_second_read got %h expected %h", got, exp); else passCount++;
        end
        checkCount++;
        if (rdCyc.size() !== 2) $display("FAIL wrap_rd_count got %0d expected 2", rdCyc.size()); else passCount++;
        for (int i = 0; i < 2 && i < rdCyc.size(); i++) begin
            gw = {16'(rdCyc[i] - t), rdDataQ[i], rdFirstQ[i], rdLastQ[i]};
            ew = (i == 0) ? {16'd7, memWord(2'd3, 12'hFFF, 255), 1'b1, 1'b0}
                          : {16'd17, memWord(2'd0, 12'd0, 0), 1'b0, 1'b1};
            checkCount++;
            if (gw !== ew) $display("FAIL wrap_word[%0d] got %h expected %h", i, gw, ew); else passCount++;
        end
        checkCount++;
        if (ok !== 1'b1 || doneCyc.size() !== 1 || doneCyc[0] - t !== 20)
            $display("FAIL wrap_done got count %0d expected 1 at offset 20", doneCyc.size());
        else passCount++;
    endtask

    task automatic test_zero_len();
        int a;
        clearLogs();
        @(negedge sys_clk);
        req_valid = 1'b1;
        req_addr  = {2'd2, 12'd3, 8'd4};
        req_len   = 10'd0;
        a         = cyc;
        #1;
        checkCount++;
        if (req_ready !== 1'b1) $display("FAIL zero_ready got %b expected 1", req_ready); else passCount++;
        @(negedge sys_clk);
        #1;
        checkCount++;
        if ({done, busy, req_ready} !== 3'b110)
            $display("FAIL zero_done_cycle got %b expected 110", {done, busy, req_ready});
        else passCount++;
        @(negedge sys_clk);
        req_valid = 1'b0;
        repeat (4) @(negedge sys_clk);
        #1;
        checkCount++;
        if ({32'(cmdCyc.size()), 32'(rdCyc.size())} !== 64'd0)
            $display("FAIL zero_activity got cmds %0d words %0d expected 0 0", cmdCyc.size(), rdCyc.size());
        else passCount++;
        checkCount++;
        if (doneCyc.size() !== 1 || doneCyc[0] !== a + 1)
            $display("FAIL zero_done got count %0d expected 1 at cycle %0d", doneCyc.size(), a + 1);
        else passCount++;
        init_end  = 1'b0;
        req_valid = 1'b1;
        req_len   = 10'd4;
        #1;
        checkCount++;
        if (req_ready !== 1'b0) $display("FAIL no_init_ready got %b expected 0", req_ready); else passCount++;
        repeat (5) @(negedge sys_clk);
        #1;
        checkCount++;
        if ({busy, req_ready, 32'(cmdCyc.size())} !== 34'd0)
            $display("FAIL no_init_hold got busy %b cmds %0d expected 0 0", busy, cmdCyc.size());
        else passCount++;
        req_valid = 1'b0;
        init_end  = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_burst();
        int a, t; logic rdy; int preCount;
        clearLogs();
        sendReq(2'd0, 12'd3, 8'd0, 10'd8, a, rdy);
        t = a + 1;
        repeat (5) @(negedge sys_clk);
        checkCount++;
        if (busy !== 1'b1 || cyc !== t + 5) $display("FAIL abort_setup got busy %b cycle %0d expected 1 %0d", busy, cyc, t + 5);
        else passCount++;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        #1;
        checkCount++;
        if ({busy, rd_valid, done, cmd_o, ba_o, addr_o} !== {3'b000, CMD_NOP, 2'b11, 12'hFFF})
            $display("FAIL abort_state got %h expected %h", {busy, rd_valid, done, cmd_o, ba_o, addr_o},
                     {3'b000, CMD_NOP, 2'b11, 12'hFFF});
        else passCount++;
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        #1;
        preCount = 0;
        foreach (cmdCode[i]) if (cmdCode[i] === CMD_PRECHARGE) preCount++;
        checkCount++;
        if (preCount !== 0 || cmdCyc.size() !== 2)
            $display("FAIL abort_cmds got pre %0d total %0d expected 0 2", preCount, cmdCyc.size());
        else passCount++;
        checkCount++;
        if (rdCyc.size() !== 0 || req_ready !== 1'b1)
            $display("FAIL abort_after got words %0d ready %b expected 0 1", rdCyc.size(), req_ready);
        else passCount++;
    endtask

    task automatic test_full_page();
        int a, t; logic rdy; bit ok; int badWords;
        clearLogs();
        sendReq(2'd2, 12'd9, 8'd0, 10'd256, a, rdy);
        t = a + 1;
        waitDone(400, ok);
        checkCount++;
        if (ok !== 1'b1) $display("FAIL page_timeout got %b expected 1", ok); else passCount++;
        checkCount++;
        if (cmdCyc.size() !== 4 || cmdCode[2] !== CMD_BURST_TER || cmdCyc[2] - t !== 259)
            $display("FAIL page_bst got count %0d expected BST at offset 259", cmdCyc.size());
        else passCount++;
        checkCount++;
        if (cmdCyc.size() !== 4 || cmdCode[3] !== CMD_PRECHARGE || cmdCyc[3] - t !== 262)
            $display("FAIL page_pre got count %0d expected PRECHARGE at offset 262", cmdCyc.size());
        else passCount++;
        checkCount++;
        if (rdCyc.size() !== 256) $display("FAIL page_rd_count got %0d expected 256", rdCyc.size()); else passCount++;
        badWords = 0;
        for (int i = 0; i < rdCyc.size() && i < 256; i++) begin
            if ({16'(rdCyc[i] - t), rdDataQ[i], rdFirstQ[i], rdLastQ[i]} !==
                {16'(7 + i), memWord(2'd2, 12'd9, i), i == 0, i == 255}) badWords++;
        end
        checkCount++;
        if (badWords !== 0) $display("FAIL page_words got %0d bad words expected 0", badWords); else passCount++;
        checkCount++;
        if (doneCyc.size() !== 1 || doneCyc[0] - t !== 265)
            $display("FAIL page_done got count %0d expected 1 at offset 265", doneCyc.size());
        else passCount++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_page_cross();
        test_bank_wrap();
        test_zero_len();
        test_reset_mid_burst();
        test_full_page();
        checkCount++;
        if (zeroDataViol !== 0) $display("FAIL rd_data_idle got %0d nonzero cycles expected 0", zeroDataViol);
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
